bcd_display_stage: RTL

BCD_DISPLAY_STAGE -- requirements
Module: bcd_display_stage

---
 rtl/bcd_display_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_display_stage.sv
// Two-digit BCD display stage: synchronizes an asynchronous units digit, extends it with a
// tens counter, and time-multiplexes both digits onto one seven-segment output.
`timescale 1ns/1ps
module bcd_display_stage #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] units_in,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic [3:0] units_sync,
    output logic [3:0] tens,
    output logic       carry,
    output logic       err
);

    localparam logic [7:0] REFRESH_TERM = 8'(REFRESH_DIV - 1);

    function automatic logic [6:0] encodeSeg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1111110;
            4'd1:    pattern = 7'b0110000;
            4'd2:    pattern = 7'b1101101;
            4'd3:    pattern = 7'b1111001;
            4'd4:    pattern = 7'b0110011;
            4'd5:    pattern = 7'b1011011;
            4'd6:    pattern = 7'b1011111;
            4'd7:    pattern = 7'b1110000;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1111011;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

    logic [3:0] s1_q, s2_q, s3_q;
    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic       carry_q, carry_d;
    logic       err_q, err_d;
    logic [3:0] dispUnits_q, dispUnits_d;
    logic [3:0] dispTens_q, dispTens_d;
    logic [7:0] refresh_q, refresh_d;
    logic [1:0] digSel_q, digSel_d;
    logic [6:0] seg_q, seg_d;
    logic       stable;

    always_comb begin
        stable      = (s2_q == s3_q);
        units_d     = units_q;
        tens_d      = tens_q;
        carry_d     = 1'b0;
        err_d       = err_q;
        dispUnits_d = dispUnits_q;
        dispTens_d  = dispTens_q;
        refresh_d   = refresh_q + 8'd1;
        digSel_d    = digSel_q;

        // Only a sample seen identically on two consecutive edges may be accepted, so
        // ripple-counter glitches (including the 1010 clear transient) are filtered out.
        if (stable) begin
            if (s2_q <= 4'd9) begin
                units_d = s2_q;
                if (units_q == 4'd9 && s2_q == 4'd0) begin
                    tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                    carry_d = (tens_q == 4'd9);
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (!hold) begin
            dispUnits_d = units_q;
            dispTens_d  = tens_q;
        end

        if (refresh_q == REFRESH_TERM) begin
            refresh_d = 8'd0;
            digSel_d  = {digSel_q[0], digSel_q[1]};
        end

        // Encoding from next-state values keeps seg aligned with dig_sel in every cycle.
        seg_d = encodeSeg(digSel_d[0] ? dispUnits_d : dispTens_d);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q        <= 4'd0;
            s2_q        <= 4'd0;
            s3_q        <= 4'd0;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            dispUnits_q <= 4'd0;
            dispTens_q  <= 4'd0;
            refresh_q   <= 8'd0;
            digSel_q    <= 2'b01;
            seg_q       <= 7'b1111110;
        end else begin
            s1_q        <= units_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            units_q     <= units_d;
            tens_q      <= tens_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            dispUnits_q <= dispUnits_d;
            dispTens_q  <= dispTens_d;
            refresh_q   <= refresh_d;
            digSel_q    <= digSel_d;
            seg_q       <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = digSel_q;
    assign units_sync = units_q;
    assign tens       = tens_q;
    assign carry      = carry_q;
    assign err        = err_q;

endmodule
